alarm_tone_gen: RTL
===================

Name: alarm_tone_gen

Overview:
- Parametrised alarm sounder for the chronometer/timer subsystem.
- When the count-finished flag rises, drives a buzzer output with a selectable pattern:
  - audio-frequency beep bursts,
  - a continuous tone until cancelled,
  - a slow square wave (legacy buzzer).
- Beep count is set at run time. Busy and done status go back to the control FSM.

Parameters:
- TONE_HALF, 25000, tone half-period in clock cycles (2 kHz at 100 MHz).
- BEEP_ON_CYC, 25000000, length of one beep ON phase in cycles.
- BEEP_OFF_CYC, 25000000, silent gap between beeps in cycles.
- SLOW_HALF, 25000000, half-period of the legacy slow square wave in cycles.
- CNT_W, 25, width of the phase and tone counters; must hold the largest of the above.
- IDLE_LEVEL, 0, audio_out value when not sounding.

Ports:
- CLK_NexYs  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- trigger  in  1  level flag from the chronometer; only its rising edge starts an alarm.
- stop  in  1  synchronous cancel, level-sensitive.
- mode  in  2  00 = beep burst, 01 = continuous tone, 10 = legacy slow square, 11 = same as 00.
- num_beeps  in  6  beeps (mode 00) or slow periods (mode 10); ignored in mode 01.
- audio_out  out  1  buzzer drive (registered).
- busy  out  1  high while an alarm sequence is active.
- done  out  1  one-cycle pulse on natural completion.

Behaviour:
- Reset (async, RST=1):
  - State goes to IDLE; all counters go to 0.
  - Edge-detect register goes to 0, so a trigger held high through reset fires on the first edge after reset.
  - Outputs: audio_out=IDLE_LEVEL, busy=0, done=0.
- Trigger detection: trig_q registers trigger every cycle. A start is trigger=1 && trig_q=0, sampled at edge t.
- Latching at start: mode and num_beeps are latched at edge t; later changes are ignored until IDLE.
- State transitions after a start at edge t:
  - Start with num_beeps=0 in mode 00/10: stay IDLE, done=1 for cycle t+1, busy stays 0, no audio.
  - Otherwise busy=1 from cycle t+1.
  - Mode 00 enters ON; mode 01 enters TONE; mode 10 enters SLOW.
- ON state (mode 00):
  - Tone counter restarts at 0 on entry; audio_out=!IDLE_LEVEL in the first ON cycle.
  - audio_out toggles every TONE_HALF cycles.
  - Lasts exactly BEEP_ON_CYC cycles, then the beep counter increments.
  - If the beep count equals the latched num_beeps, go to IDLE. Otherwise go to OFF.
- OFF state: audio_out=IDLE_LEVEL for exactly BEEP_OFF_CYC cycles, then back to ON. There is no trailing OFF after the last beep.
- TONE state (mode 01): the same tone generator as ON, running indefinitely. It exits only on stop.
- SLOW state (mode 10):
  - audio_out=!IDLE_LEVEL on entry and toggles every SLOW_HALF cycles.
  - No audio carrier.
  - Exits to IDLE after 2*num_beeps half-periods.
- Natural exit to IDLE: in the first IDLE cycle, done=1 for one cycle, busy=0, audio_out=IDLE_LEVEL.
- stop=1 at any edge while busy:
  - Next cycle: IDLE, audio_out=IDLE_LEVEL, busy=0.
  - done is NOT pulsed.
- Simultaneous events:
  - stop and a trigger edge in the same cycle while IDLE: stop wins and no start occurs.
  - A trigger edge while busy is ignored (no restart). trig_q still tracks trigger.
- Counters: each wraps to 0 when its terminal count is reached. No other wrap-around is permitted.
  - Phase counter compares against (param-1).
  - Beep/half-period counter is 7 bits, so 2*63 fits.
- Constraint: all parameters must be ≥1.

Test Plan:
Benches override parameters to TONE_HALF=2, BEEP_ON_CYC=8, BEEP_OFF_CYC=4, SLOW_HALF=3, IDLE_LEVEL=0.

1. Mode 00, num_beeps=3, trigger rises at edge t:
   - audio_out follows 1,1,0,0,1,1,0,0 during t+1..t+8, t+13..t+20 and t+25..t+32.
   - audio_out=0 during t+9..t+12 and t+21..t+24.
   - busy=1 over t+1..t+32.
   - done=1 only at t+33.
2. Mode 10, num_beeps=2:
   - audio_out = 1,1,1,0,0,0,1,1,1,0,0,0 over t+1..t+12.
   - done at t+13, then audio_out stays 0.
3. Mode 01:
   - Tone 1,1,0,0,… runs for 100 cycles.
   - Assert stop at edge s: at s+1, audio_out=0 and busy=0, with no done pulse.
4. Retrigger and edge-only behaviour:
   - During a mode 00 run, pulse trigger low then high: the sequence timing is unchanged.
   - Hold trigger high after completion: no second start occurs.
5. Zero count, mode 00 with num_beeps=0:
   - done=1 for one cycle at t+1, busy never rises, audio_out stays 0.
   - In the same run, assert stop together with a trigger edge while IDLE: no start occurs.
6. Reset mid-operation:
   - Assert RST asynchronously mid-beep: outputs go to 0 immediately.
   - With trigger held high through reset release, a fresh sequence starts on the first clock edge after reset.

Source files
------------

// File: rtl/alarm_tone_gen.sv
// Alarm sounder: beep bursts, continuous tone or slow square wave,
// started by the rising edge of the chronometer's count-finished flag.
module alarm_tone_gen #(
    parameter int   TONE_HALF    = 25000,
    parameter int   BEEP_ON_CYC  = 25000000,
    parameter int   BEEP_OFF_CYC = 25000000,
    parameter int   SLOW_HALF    = 25000000,
    parameter int   CNT_W        = 25,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input  logic       CLK_NexYs,
    input  logic       RST,
    input  logic       trigger,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic [5:0] num_beeps,
    output logic       audio_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        ON,
        OFF,
        TONE,
        SLOW
    } state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_HALF - 1);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(BEEP_ON_CYC - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(BEEP_OFF_CYC - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_HALF - 1);

    state_t           state_q;
    logic             trig_q;
    logic [5:0]       num_q;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] tone_cnt;
    logic [6:0]       beep_cnt;

    logic       start;
    logic       tone_wrap;
    logic       on_end;
    logic       off_end;
    logic       slow_end;
    logic [6:0] beep_next;
    logic       last_beep;
    logic       last_half;

    assign start     = trigger && !trig_q;
    assign tone_wrap = (tone_cnt == TONE_LAST);
    assign on_end    = (phase_cnt == ON_LAST);
    assign off_end   = (phase_cnt == OFF_LAST);
    assign slow_end  = (phase_cnt == SLOW_LAST);
    assign beep_next = beep_cnt + 7'd1;
    assign last_beep = (beep_next == {1'b0, num_q});
    // Slow mode counts half-periods, so compare against twice the count.
    assign last_half = (beep_next == {num_q, 1'b0});

    always_ff @(posedge CLK_NexYs or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            trig_q    <= 1'b0;
            num_q     <= '0;
            phase_cnt <= '0;
            tone_cnt  <= '0;
            beep_cnt  <= '0;
            audio_out <= IDLE_LEVEL;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            trig_q <= trigger;
            done   <= 1'b0;
            if (stop) begin
                state_q   <= IDLE;
                phase_cnt <= '0;
                tone_cnt  <= '0;
                beep_cnt  <= '0;
                audio_out <= IDLE_LEVEL;
                busy      <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            num_q     <= num_beeps;
                            phase_cnt <= '0;
                            tone_cnt  <= '0;
                            beep_cnt  <= '0;
                            if (mode == 2'b01) begin
                                state_q   <= TONE;
                                busy      <= 1'b1;
                                audio_out <= ~IDLE_LEVEL;
                            end else if (num_beeps == 6'd0) begin
                                done <= 1'b1;
                            end else if (mode == 2'b10) begin
                                state_q   <= SLOW;
                                busy      <= 1'b1;
                                audio_out <= ~IDLE_LEVEL;
                            end else begin
                                state_q   <= ON;
                                busy      <= 1'b1;
                                audio_out <= ~IDLE_LEVEL;
                            end
                        end
                    end
                    ON: begin
                        tone_cnt <= tone_wrap ? '0 : tone_cnt + ONE;
                        if (tone_wrap) begin
                            audio_out <= ~audio_out;
                        end
                        if (on_end) begin
                            phase_cnt <= '0;
                            tone_cnt  <= '0;
                            beep_cnt  <= beep_next;
                            audio_out <= IDLE_LEVEL;
                            if (last_beep) begin
                                state_q  <= IDLE;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                beep_cnt <= '0;
                            end else begin
                                state_q <= OFF;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + ONE;
                        end
                    end
                    OFF: begin
                        if (off_end) begin
                            phase_cnt <= '0;
                            tone_cnt  <= '0;
                            state_q   <= ON;
                            audio_out <= ~IDLE_LEVEL;
                        end else begin
                            phase_cnt <= phase_cnt + ONE;
                        end
                    end
                    TONE: begin
                        tone_cnt <= tone_wrap ? '0 : tone_cnt + ONE;
                        if (tone_wrap) begin
                            audio_out <= ~audio_out;
                        end
                    end
                    SLOW: begin
                        if (slow_end) begin
                            phase_cnt <= '0;
                            if (last_half) begin
                                state_q   <= IDLE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                beep_cnt  <= '0;
                                audio_out <= IDLE_LEVEL;
                            end else begin
                                beep_cnt  <= beep_next;
                                audio_out <= ~audio_out;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + ONE;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        busy      <= 1'b0;
                        audio_out <= IDLE_LEVEL;
                    end
                endcase
            end
        end
    end

endmodule
